// File: rtl/updown_seq_pkg.sv
// updown_seq_pkg: shared state encoding and command mode constants for the up/down sequencer
package updown_seq_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN_UP = 2'd1,
    RUN_DN = 2'd2,
    DONE   = 2'd3
  } state_e;
  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;
endpackage

// File: rtl/updown_core.sv
// updown_core: modulo up/down counter with synchronous load taking priority over enable
module updown_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] cout
);
  logic [WIDTH-1:0] cout_q, cout_d;
  always_comb cout_d = ld ? din : en ? (up ? cout_q + WIDTH'(1) : cout_q - WIDTH'(1)) : cout_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cout_q <= '0;
    else cout_q <= cout_d;
  assign cout = cout_q;
endmodule

// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl: accepts one start/target/mode command and steps a counter toward the target
module updown_seq_ctrl
  import updown_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic             hold,
  output logic [WIDTH-1:0] cout,
  output logic             dir_up,
  output logic             busy,
  output logic             done,
  output logic             err
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] start_q, target_q, inc, dec, dn_end;
  logic [1:0]       mode_q;
  logic             err_q, ld, en, accept;
  assign accept = cmd_valid && cmd_ready;
  assign inc    = cout + WIDTH'(1);
  assign dec    = cout - WIDTH'(1);
  // a bounce run returns to its start value on the way down
  assign dn_end = mode_q == MODE_BOUNCE ? start_q : target_q;
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    en      = 1'b0;
    case (state_q)
      IDLE: if (accept && cmd_mode != MODE_RSVD) begin
        ld      = 1'b1;
        state_d = cmd_start == cmd_target ? DONE : cmd_mode == MODE_DOWN ? RUN_DN : RUN_UP;
      end
      RUN_UP: if (!hold) begin
        en = 1'b1;
        if (inc == target_q) state_d = mode_q == MODE_BOUNCE ? RUN_DN : DONE;
      end
      RUN_DN: if (!hold) begin
        en = 1'b1;
        if (dec == dn_end) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      start_q  <= '0;
      target_q <= '0;
      mode_q   <= MODE_UP;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && cmd_mode == MODE_RSVD;
      if (ld) begin
        start_q  <= cmd_start;
        target_q <= cmd_target;
        mode_q   <= cmd_mode;
      end
    end
  updown_core #(.WIDTH(WIDTH)) u_core (
    .clk (clk),
    .rst (reset),
    .ld  (ld),
    .din (cmd_start),
    .en  (en),
    .up  (dir_up),
    .cout(cout)
  );
  assign cmd_ready = state_q == IDLE;
  assign dir_up    = state_q == RUN_UP;
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err       = err_q;
endmodule

// File: tb/tb_updown_seq_ctrl.sv
// tb_updown_seq_ctrl: vector table, corner sequences and random run against a path-queue model
module tb_updown_seq_ctrl;
  logic       clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, hold = 1'b0;
  logic [1:0] cmd_mode = 2'b00;
  logic [3:0] cmd_start = 4'd0, cmd_target = 4'd0;
  logic       cmd_ready, dir_up, busy, done, err;
  logic [3:0] cout;
  int tests = 0, fails = 0;

  updown_seq_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_start(cmd_start), .cmd_target(cmd_target), .hold(hold),
    .cout(cout), .dir_up(dir_up), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // model: phase 0 idle, 1 running, 2 done; q holds the values still to be visited
  int m_ph, m_cout, q[$];
  bit m_err;

  task automatic m_reset();
    m_ph = 0; m_cout = 0; m_err = 0; q.delete();
  endtask

  task automatic walk(input int a, input int b, input int d);
    int v;
    if (a == b) return;
    v = a;
    do begin
      v = (v + d) & 15;
      q.push_back(v);
    end while (v != b);
  endtask

  task automatic m_edge(input bit v, input int md, input int s, input int t, input bit h);
    m_err = 0;
    if (m_ph == 0) begin
      if (v) begin
        if (md == 3) m_err = 1;
        else begin
          m_cout = s;
          q.delete();
          if (md != 1) walk(s, t, 1);
          if (md == 1) walk(s, t, -1);
          if (md == 2) walk(t, s, -1);
          m_ph = q.size() == 0 ? 2 : 1;
        end
      end
    end else if (m_ph == 1) begin
      if (!h) begin
        m_cout = q.pop_front();
        if (q.size() == 0) m_ph = 2;
      end
    end else m_ph = 0;
  endtask

  task automatic chk_model(input string n);
    bit mdir;
    mdir = m_ph == 1 && q[0] == ((m_cout + 1) & 15);
    chk({n, " cout"}, cout, m_cout[7:0]);
    chk({n, " ready"}, cmd_ready, m_ph == 0);
    chk({n, " busy"}, busy, m_ph != 0);
    chk({n, " done"}, done, m_ph == 2);
    chk({n, " err"}, err, m_err);
    chk({n, " dir_up"}, dir_up, mdir);
  endtask

  task automatic cyc(input bit v, input int md, input int s, input int t, input bit h);
    cmd_valid = v; cmd_mode = md[1:0]; cmd_start = s[3:0]; cmd_target = t[3:0]; hold = h;
    m_edge(v, md, s, t, h);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit v; int md, s, t; bit h;
    int c; bit rdy, bsy, dn, er, dir;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit v, input int md, input int s, input int t, input bit h,
                     input int c, input bit rdy, input bit bsy, input bit dn, input bit er, input bit dir);
    vec_t x;
    x.v = v; x.md = md; x.s = s; x.t = t; x.h = h;
    x.c = c; x.rdy = rdy; x.bsy = bsy; x.dn = dn; x.er = er; x.dir = dir;
    tbl.push_back(x);
  endtask

  initial begin
    int n, held;
    bit h;
    int bc[7] = '{2, 3, 4, 5, 4, 3, 2};
    bit bd[7] = '{1, 1, 1, 0, 0, 0, 0};
    m_reset();
    #1;
    chk("reset cout", cout, 0);
    chk("reset busy", busy, 0);
    chk("reset ready", cmd_ready, 1);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    add(1, 0, 3, 6, 0,   3, 0, 1, 0, 0, 1);
    add(1, 1, 9, 9, 0,   4, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0,   5, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0,   6, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 1,   6, 1, 0, 0, 0, 0);
    add(1, 1, 1, 14, 0,  1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  15, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  14, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,  14, 1, 0, 0, 0, 0);
    add(1, 3, 5, 9, 0,  14, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0,  14, 1, 0, 0, 0, 0);
    add(1, 0, 7, 7, 0,   7, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0,   7, 1, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].md, tbl[i].s, tbl[i].t, tbl[i].h);
      chk($sformatf("vec%0d cout", i), cout, tbl[i].c[7:0]);
      chk($sformatf("vec%0d ready", i), cmd_ready, tbl[i].rdy);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d done", i), done, tbl[i].dn);
      chk($sformatf("vec%0d err", i), err, tbl[i].er);
      chk($sformatf("vec%0d dir_up", i), dir_up, tbl[i].dir);
    end

    for (int i = 0; i < 7; i++) begin
      if (i == 0) cyc(1, 2, 2, 5, 0);
      else cyc(0, 0, 0, 0, 0);
      chk($sformatf("bounce%0d cout", i), cout, bc[i][7:0]);
      chk($sformatf("bounce%0d dir_up", i), dir_up, bd[i]);
      chk($sformatf("bounce%0d done", i), done, i == 6);
    end
    cyc(0, 0, 0, 0, 0);
    chk("bounce ready", cmd_ready, 1);

    cyc(1, 0, 0, 4, 0);
    n = 0; held = 0;
    while (!done && n < 20) begin
      h = cout == 2 && held < 3;
      if (h) held++;
      cyc(0, 0, 0, 0, h);
      n++;
      if (h) chk("hold freeze", cout, 2);
    end
    chk("hold edges", n[7:0], 7);
    chk("hold final", cout, 4);
    cyc(0, 0, 0, 0, 0);
    chk("hold single done", done, 0);
    chk("hold ready", cmd_ready, 1);

    cyc(1, 0, 0, 15, 0);
    n = 0;
    while (cout != 9 && n < 20) begin
      cyc(0, 0, 0, 0, 0);
      n++;
    end
    chk("abort reach 9", cout, 9);
    #3 reset = 1'b1;
    #1;
    chk("abort cout", cout, 0);
    chk("abort busy", busy, 0);
    chk("abort ready", cmd_ready, 1);
    chk("abort done", done, 0);
    chk("abort dir_up", dir_up, 0);
    m_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk_model("post-abort");
    end

    for (int i = 0; i < 1500; i++) begin
      int s, t;
      s = $urandom_range(0, 15);
      t = $urandom_range(0, 7) == 0 ? s : $urandom_range(0, 15);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3), s, t, $urandom_range(0, 3) == 0);
      chk_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/updown_seq_ctrl.md
Name: updown_seq_ctrl

Overview:
Command-driven sequencer for a WIDTH-bit up/down counter.
- Accepts one command at a time over a valid/ready handshake: start value, target value, mode.
- Loads the counter, then steps it one count per clock toward the target: up, down, or up then back down (bounce).
- Signals completion with a one-cycle done pulse.
- Sits between a host/test controller and any logic consuming the count, such as a sweep address or a PWM compare value.

Parameters:
WIDTH, 4, counter and start/target width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_mode  input  2  00 UP, 01 DOWN, 10 BOUNCE, 11 reserved
cmd_start  input  WIDTH  value loaded into counter on accept
cmd_target  input  WIDTH  value at which the run ends (BOUNCE: turn-around point)
hold  input  1  freezes stepping while high
cout  output  WIDTH  current count
dir_up  output  1  1 while stepping up, 0 while stepping down or idle
busy  output  1  high in RUN_UP/RUN_DN/DONE
done  output  1  one-cycle pulse, run complete
err  output  1  one-cycle pulse, reserved mode received

Behaviour:
- One clock (clk). Reset is asynchronous and active-high: asserting reset immediately forces the following, regardless of clk:
  - state IDLE
  - cout 0
  - dir_up 0, busy 0, done 0, err 0
  - cmd_ready 1 once reset deasserts
- States: IDLE, RUN_UP, RUN_DN, DONE.
- Accept: cmd_valid && cmd_ready at a clk edge.
  - Latches start_r = cmd_start, target_r = cmd_target, mode_r = cmd_mode.
  - Loads cout <= cmd_start.
  - cmd_ready drops the cycle after accept.
- Accept transitions:
  - UP -> RUN_UP; DOWN -> RUN_DN; BOUNCE -> RUN_UP (phase 1).
  - If cmd_start == cmd_target (modes 00/01/10): go directly to DONE; no stepping.
  - Mode 11: cout unchanged, state stays IDLE, err high for exactly the next cycle, done not asserted.
- RUN_UP, edge with hold=0:
  - cout <= cout+1, modulo 2^WIDTH (15 -> 0 wraps, no saturation).
  - If cout+1 == target_r:
    - mode UP -> DONE.
    - mode BOUNCE -> RUN_DN, with the run end now start_r.
- RUN_DN, edge with hold=0:
  - cout <= cout-1, modulo 2^WIDTH (0 -> 15).
  - Stops and goes to DONE when the new value equals the active end: target_r for DOWN, start_r for BOUNCE phase 2.
- hold=1 in RUN_*: cout and state frozen. hold is ignored in IDLE and DONE.
- DONE: done=1 for exactly one cycle, then IDLE. cout retains its final value until the next accept.
- dir_up = 1 only in RUN_UP.
- Latency: a run of n steps accepted at edge k, with no holds, has the final value at edge k+n, done high in the following cycle, and cmd_ready back high after edge k+n+1.
- Command inputs are ignored outside IDLE; no queuing.
- Reset mid-run aborts the run. No done pulse is generated, and latched command state is discarded.

Decomposition:
- Package updown_seq_pkg:
  - state encoding (IDLE=0, RUN_UP=1, RUN_DN=2, DONE=3)
  - mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_BOUNCE=2'b10, MODE_RSVD=2'b11
- Sub-module updown_core (WIDTH):
  - Counter with async active-high reset, synchronous load (ld, din), enable (en) and direction (up).
  - Load has priority over enable.
  - The controller FSM drives ld/en/up; updown_core owns cout.

Test Plan:
1. Reset check: assert reset mid-cycle with cout=9 -> cout=0, busy=0, cmd_ready=1 immediately, without waiting for clk.
2. UP, start=3, target=6, hold=0, accepted at edge k -> cout 3,4,5,6 at edges k..k+3; done high one cycle after k+3; cmd_ready high after k+4.
3. DOWN with wrap, start=1, target=14 -> cout 1,0,15,14; dir_up=0 throughout; single done pulse.
4. BOUNCE, start=2, target=5 -> cout 2,3,4,5,4,3,2; dir_up 1 during 3..5 then 0; done after returning to 2.
5. UP, start=0, target=4, hold=1 for 3 cycles while cout=2 -> cout stays 2 for 3 cycles; total run 4 steps + 3 held cycles; done once.
6. Edge cases:
   - start=target=7 (mode UP) -> DONE next cycle, cout=7, no steps.
   - mode 11 -> err one cycle, cout unchanged, no done, cmd_ready stays 1.
   - reset asserted during RUN_UP -> no done pulse, IDLE, cout=0.
